// File: rtl/display.sv
// Single-digit seven-segment hex display driver.
//
// The four switch inputs {w,x,y,z} form a hex nibble that is treated as
// asynchronous: it passes through a two-flop synchronizer, is decoded, and
// is registered onto the segment outputs. Input-to-output latency is three
// rising edges. A valid bit travels alongside the data so that the display
// stays blank after reset until the first real decoded pattern arrives.
//
// Ports
//   clk            : clock, rising edge
//   rst            : synchronous reset, active high
//   w, x, y, z     : hex digit bits 3..0 (asynchronous switches)
//   a..g           : segment cathodes, active low (0 = lit)
//   an0..an3       : digit anodes, active low; only digit 0 is ever enabled
// All outputs come straight from flip-flops.
module display (
  input  logic clk,
  input  logic rst,
  input  logic w,
  input  logic x,
  input  logic y,
  input  logic z,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic e,
  output logic f,
  output logic g,
  output logic an0,
  output logic an1,
  output logic an2,
  output logic an3
);

  // Valid stages line up with the two synchronizer flops.
  localparam int STAGES = 1;

  logic [3:0]      sync1, sync2;
  logic [STAGES:0] vld_pipe;
  logic [6:0]      seg_dec;   // {a,b,c,d,e,f,g}, active low
  logic [6:0]      seg_q;
  logic [3:0]      an_q;      // {an0,an1,an2,an3}

  // Hex decode; every code is legal, the blank default is never selected.
  always_comb begin
    seg_dec = 7'h7f;
    case (sync2)
      4'h0: seg_dec = 7'b0000001;
      4'h1: seg_dec = 7'b1001111;
      4'h2: seg_dec = 7'b0010010;
      4'h3: seg_dec = 7'b0000110;
      4'h4: seg_dec = 7'b1001100;
      4'h5: seg_dec = 7'b0100100;
      4'h6: seg_dec = 7'b0100000;
      4'h7: seg_dec = 7'b0001111;
      4'h8: seg_dec = 7'b0000000;
      4'h9: seg_dec = 7'b0000100;
      4'ha: seg_dec = 7'b0001000;
      4'hb: seg_dec = 7'b1100000;
      4'hc: seg_dec = 7'b0110001;
      4'hd: seg_dec = 7'b1000010;
      4'he: seg_dec = 7'b0110000;
      4'hf: seg_dec = 7'b0111000;
      default: seg_dec = 7'h7f;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      vld_pipe <= '0;
      seg_q    <= '1;
      an_q     <= '1;
    end else begin
      sync1    <= {w, x, y, z};
      sync2    <= sync1;
      vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
      // sync2 holds the reset value until it has seen a real sample, so the
      // valid bit gates it to keep the display blank in the meantime.
      seg_q    <= vld_pipe[STAGES] ? seg_dec : 7'h7f;
      an_q     <= {~vld_pipe[STAGES], 3'b111};
    end
  end

  assign {a, b, c, d, e, f, g}  = seg_q;
  assign {an0, an1, an2, an3}   = an_q;

endmodule

// File: tb/tb_display.sv
module tb_display;

  logic clk = 1'b0;
  logic rst, w, x, y, z;
  logic a, b, c, d, e, f, g, an0, an1, an2, an3;

  display dut (
    .clk(clk), .rst(rst), .w(w), .x(x), .y(y), .z(z),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
    .an0(an0), .an1(an1), .an2(an2), .an3(an3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] seg;
    logic [3:0] an;
  } exp_t;

  exp_t exp_q[$];
  bit   rst_h[$];
  int   n_h[$];
  int   tests = 0;
  int   fails = 0;

  // Segment letters lit for each hex value, straight from the display table.
  string lit [16] = '{"abcdef", "bc", "abdeg", "abcdg",
                      "bcfg", "acdfg", "acdefg", "abc",
                      "abcdefg", "abcdfg", "abcefg", "cdefg",
                      "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] pattern(int n);
    logic [6:0] m;
    string s;
    m = 7'h7f;
    s = lit[n];
    for (int i = 0; i < s.len(); i++)
      m[6 - int'(s[i] - "a")] = 1'b0;
    return m;
  endfunction

  // Expected outputs after the coming edge: data sampled two edges earlier
  // shows only if reset was low on that edge and the two since.
  function automatic exp_t model();
    exp_t r;
    int k;
    k = rst_h.size() - 1;
    if (rst_h[k] || rst_h[k-1] || rst_h[k-2]) begin
      r.seg = 7'h7f;
      r.an  = 4'hf;
    end else begin
      r.seg = pattern(n_h[k-2]);
      r.an  = 4'b0111;
    end
    return r;
  endfunction

  task automatic step(bit r, int n, int cycles);
    for (int i = 0; i < cycles; i++) begin
      rst = r;
      {w, x, y, z} = n[3:0];
      rst_h.push_back(r);
      n_h.push_back(n);
      exp_q.push_back(model());
      @(negedge clk);
    end
  endtask

  // Monitor: one expected entry per rising edge.
  initial begin
    exp_t ex;
    forever begin
      @(posedge clk);
      #1;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL underflow: output at %0t with no expectation", $time);
      end else begin
        ex = exp_q.pop_front();
        if ({a, b, c, d, e, f, g} !== ex.seg) begin
          fails++;
          $display("FAIL seg @%0t: got %b want %b", $time, {a, b, c, d, e, f, g}, ex.seg);
        end
        tests++;
        if ({an0, an1, an2, an3} !== ex.an) begin
          fails++;
          $display("FAIL anode @%0t: got %b want %b", $time, {an0, an1, an2, an3}, ex.an);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // History before time zero counts as reset.
    rst_h.push_back(1'b1); rst_h.push_back(1'b1);
    n_h.push_back(0);      n_h.push_back(0);

    step(1, 0, 2);                          // reset
    step(0, 0, 5);                          // release with 0
    for (int v = 0; v < 16; v++) step(0, v, 4);   // sweep
    step(0, 1, 5);                          // 1 -> 7 latency
    step(0, 7, 5);
    step(0, 0, 3);                          // one-cycle pulse of A
    step(0, 10, 1);
    step(0, 0, 5);
    step(0, 6, 5);                          // reset mid-display
    step(1, 6, 1);
    step(0, 6, 5);
    step(1, 3, 2);                          // longer reset
    step(0, 3, 4);
    for (int i = 0; i < 400; i++)           // random
      step(($urandom_range(0, 31) == 0), int'($urandom_range(0, 15)), 1);
    step(0, 0, 3);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
